pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Hazard sequencer for the five-stage pipeline. Watches the instruction in decode and the instruction in the decode/execution register. Generates hold, bubble and flush controls for the fetch/decode and decode/execution pipeline registers, covering load-use hazards, multi-cycle execute ops and taken branches. Also keeps a saturating count of stall cycles for performance measurement.

## Interface
- ADDR_WIDTH, 4: register address width; matches the register file.
- MULT_CYCLES, 3: total cycles a multi-cycle op occupies execute; legal range 2..16.
- clk_i  in  1  pipeline clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous and active-low.
- dec_valid_i  in  1  the decode-stage instruction is valid.
- dec_src1_addr_i, dec_src2_addr_i, dec_src3_addr_i  in  ADDR_WIDTH each  decode-stage source addresses.
- dec_src_used_i  in  3  per-source "read" flags; bit0 = src1.
- ex_valid_i  in  1  is_valid output of the decode/execution register.
- ex_mem_read_i  in  1  the execute op is a load.
- ex_reg_write_i  in  1  the execute op writes the register file.
- ex_dest_addr_i  in  ADDR_WIDTH  destination address of the execute op.
- ex_multi_cycle_i  in  1  the execute op is multi-cycle (multiply).
- ex_branch_taken_i  in  1  execute resolved a taken branch this cycle.
- fd_hold_o  out  1  fetch/decode register and PC keep their value.
- fd_flush_o  out  1  fetch/decode register loads invalid.
- de_hold_o  out  1  decode/execution register keeps its value.
- de_bubble_o  out  1  decode/execution register loads is_valid=0.
- stall_cnt_o  out  16  saturating count of cycles with fd_hold_o=1.

## Operation
- States: IDLE, MULTI. A 4-bit down-counter cnt is used in MULTI.
- Hazard conditions, evaluated combinationally each cycle:
  - branch = ex_valid_i & ex_branch_taken_i.
  - multi = state==IDLE & ex_valid_i & ex_multi_cycle_i.
  - load_use = ex_valid_i & ex_mem_read_i & ex_reg_write_i & dec_valid_i & (any i with dec_src_used_i[i] and dec_src{i}_addr_i == ex_dest_addr_i).
- Priority: branch > MULTI/multi > load_use.
- branch, in any state:
  - fd_flush_o=1, de_bubble_o=1, holds 0.
  - Next state IDLE, cnt cleared.
- multi, in IDLE:
  - fd_hold_o=1, de_hold_o=1.
  - Next state MULTI, cnt = MULT_CYCLES-2.
- In MULTI with cnt != 0:
  - fd_hold_o=1, de_hold_o=1.
  - cnt decrements.
- In MULTI with cnt == 0:
  - No hold; the op leaves execute at this edge.
  - Next state IDLE.
  - multi detection is suppressed in MULTI, so the held op never re-triggers.
- load_use, in IDLE with no branch and no multi:
  - fd_hold_o=1, de_bubble_o=1.
  - The decode instruction stays in place; next cycle the load is in memory and the hazard clears.
- No condition: all control outputs 0.
- de_hold_o and de_bubble_o are never both 1. fd_hold_o and fd_flush_o are never both 1.
- stall_cnt_o increments on each edge where fd_hold_o=1 and saturates at 16'hFFFF.

## Timing
- Control outputs are combinational from state, cnt and inputs. They act in the same cycle the hazard is present.
- Load-use costs exactly 1 stall cycle.
- A multi-cycle op costs MULT_CYCLES-1 stall cycles and occupies execute for MULT_CYCLES cycles. With MULT_CYCLES=2, MULTI is entered with cnt=0 and stays 1 cycle.
- Branch costs a 1-cycle flush and bubble with no hold.
- Reset:
  - While rst_n_i=0, all control outputs are forced 0, state=IDLE, cnt=0, stall_cnt_o=0.
  - Assertion mid-MULTI aborts immediately and asynchronously.
  - After release, operation starts from IDLE on the next edge.
- stall_cnt_o updates one edge after the stall cycle it counts.

## Test plan
- Load-use: ex load to r3, decode reads r3 on src2 (used=3'b010) -> one cycle of fd_hold_o=1 and de_bubble_o=1; next cycle all 0; stall_cnt_o=1.
- Unused-source match: same addresses but used=3'b000 -> no stall. Same match with ex_valid_i=0 -> no stall.
- Multi, MULT_CYCLES=3: multiply enters execute -> fd_hold_o and de_hold_o high for 2 cycles, 3rd cycle low, state back to IDLE; stall_cnt_o=2. Repeat with MULT_CYCLES=2 -> 1 stall cycle.
- Branch priority: ex_branch_taken_i=1 while a load-use match is also present -> fd_flush_o=1, de_bubble_o=1, fd_hold_o=0; stall_cnt_o unchanged.
- Reset mid-multiply, MULT_CYCLES=5: assert rst_n_i low in the 2nd stall cycle -> outputs 0 immediately, stall_cnt_o=0. After release with no multi op -> no holds.
- Saturation: preload by holding load-use for 65,540 cycles -> stall_cnt_o stops at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Port bundle between the five-stage pipeline datapath and its hazard controller.
// No valid/ready pairs here: a valid flag qualifies its stage's fields, and the controls come back combinationally in the same cycle.
interface pipeline_hazard_controller_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  dec_valid_i;
    logic [ADDR_WIDTH-1:0] dec_src1_addr_i;
    logic [ADDR_WIDTH-1:0] dec_src2_addr_i;
    logic [ADDR_WIDTH-1:0] dec_src3_addr_i;
    logic [2:0]            dec_src_used_i;
    logic                  ex_valid_i;
    logic                  ex_mem_read_i;
    logic                  ex_reg_write_i;
    logic [ADDR_WIDTH-1:0] ex_dest_addr_i;
    logic                  ex_multi_cycle_i;
    logic                  ex_branch_taken_i;

    logic                  fd_hold_o;
    logic                  fd_flush_o;
    logic                  de_hold_o;
    logic                  de_bubble_o;
    logic [15:0]           stall_cnt_o;

    // Debug view of the sequencer: MULTI state flag and the remaining-cycle counter.
    logic                  dbg_multi;
    logic [3:0]            dbg_cnt;

    modport master (
        output dec_valid_i, dec_src1_addr_i, dec_src2_addr_i, dec_src3_addr_i,
        output dec_src_used_i, ex_valid_i, ex_mem_read_i, ex_reg_write_i,
        output ex_dest_addr_i, ex_multi_cycle_i, ex_branch_taken_i,
        input  fd_hold_o, fd_flush_o, de_hold_o, de_bubble_o, stall_cnt_o,
        input  dbg_multi, dbg_cnt
    );

    modport slave (
        input  dec_valid_i, dec_src1_addr_i, dec_src2_addr_i, dec_src3_addr_i,
        input  dec_src_used_i, ex_valid_i, ex_mem_read_i, ex_reg_write_i,
        input  ex_dest_addr_i, ex_multi_cycle_i, ex_branch_taken_i,
        output fd_hold_o, fd_flush_o, de_hold_o, de_bubble_o, stall_cnt_o,
        output dbg_multi, dbg_cnt
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the five-stage pipeline: load-use stalls, multi-cycle
// execute holds and taken-branch flushes, plus a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int ADDR_WIDTH  = 4,
    parameter int MULT_CYCLES = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    pipeline_hazard_controller_if.slave   hz
);

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    // MULTI is entered after the first stall cycle, so the counter covers the rest.
    localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 2);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [15:0]           stall_cnt;

    logic [ADDR_WIDTH-1:0] src_addr [3];
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic                  src_hit;
    logic                  branch;
    logic                  multi;
    logic                  load_use;

    logic                  fd_hold;
    logic                  fd_flush;
    logic                  de_hold;
    logic                  de_bubble;

    assign src_addr[0] = hz.dec_src1_addr_i;
    assign src_addr[1] = hz.dec_src2_addr_i;
    assign src_addr[2] = hz.dec_src3_addr_i;
    assign dest_addr   = hz.ex_dest_addr_i;

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (hz.dec_src_used_i[i] && (src_addr[i] == dest_addr)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign branch   = hz.ex_valid_i & hz.ex_branch_taken_i;
    assign multi    = (state == IDLE) & hz.ex_valid_i & hz.ex_multi_cycle_i;
    assign load_use = hz.ex_valid_i & hz.ex_mem_read_i & hz.ex_reg_write_i
                    & hz.dec_valid_i & src_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fd_hold   = 1'b0;
        fd_flush  = 1'b0;
        de_hold   = 1'b0;
        de_bubble = 1'b0;

        if (branch) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end else if (state == MULTI) begin
            // Load-use is not evaluated here: the held op is not a load.
            if (cnt != 4'd0) begin
                fd_hold = 1'b1;
                de_hold = 1'b1;
                cnt_nxt = cnt - 4'd1;
            end else begin
                state_nxt = IDLE;
            end
        end else if (multi) begin
            fd_hold   = 1'b1;
            de_hold   = 1'b1;
            state_nxt = MULTI;
            cnt_nxt   = CNT_INIT;
        end else if (load_use) begin
            fd_hold   = 1'b1;
            de_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= 16'd0;
        end else if (fd_hold && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Controls are squelched while reset is low so a live load-use match cannot leak out.
    assign hz.fd_hold_o   = fd_hold   & rst_n_i;
    assign hz.fd_flush_o  = fd_flush  & rst_n_i;
    assign hz.de_hold_o   = de_hold   & rst_n_i;
    assign hz.de_bubble_o = de_bubble & rst_n_i;
    assign hz.stall_cnt_o = stall_cnt;
    assign hz.dbg_multi   = (state == MULTI);
    assign hz.dbg_cnt     = cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: three instances (MULT_CYCLES 2, 3, 5) on shared stimulus,
// checked against an occupancy-based reference model plus vector tables and hand sequences.
module tb_pipeline_hazard_controller;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.ADDR_WIDTH(4)) hz2 ();
    pipeline_hazard_controller_if #(.ADDR_WIDTH(4)) hz3 ();
    pipeline_hazard_controller_if #(.ADDR_WIDTH(4)) hz5 ();

    pipeline_hazard_controller #(.ADDR_WIDTH(4), .MULT_CYCLES(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .hz(hz2.slave));
    pipeline_hazard_controller #(.ADDR_WIDTH(4), .MULT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .hz(hz3.slave));
    pipeline_hazard_controller #(.ADDR_WIDTH(4), .MULT_CYCLES(5)) dut5 (
        .clk_i(clk), .rst_n_i(rst_n), .hz(hz5.slave));

    typedef struct {
        logic       dv;
        logic [3:0] a1, a2, a3;
        logic [2:0] used;
        logic       ev, mr, rw;
        logic [3:0] dest;
        logic       mul, br;
    } stim_t;

    typedef struct {
        stim_t in;
        logic  h, f, dh, b;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   mc_tab [3] = '{2, 3, 5};
    int   occ    [3];
    int   mcnt   [3];

    logic        a_h [3], a_f [3], a_dh [3], a_b [3], a_m [3];
    logic [15:0] a_cnt [3];

    stim_t nop;
    vec_t  vecs [14];

    function automatic stim_t mk(logic dv, logic [3:0] a1, logic [3:0] a2, logic [3:0] a3,
                                 logic [2:0] used, logic ev, logic mr, logic rw,
                                 logic [3:0] dest, logic mul, logic br);
        stim_t s;
        s.dv = dv; s.a1 = a1; s.a2 = a2; s.a3 = a3; s.used = used;
        s.ev = ev; s.mr = mr; s.rw = rw; s.dest = dest; s.mul = mul; s.br = br;
        return s;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s mc=%0d: got %0h expected %0h", name, mc_tab[inst], act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        hz2.dec_valid_i = s.dv; hz2.dec_src1_addr_i = s.a1; hz2.dec_src2_addr_i = s.a2;
        hz2.dec_src3_addr_i = s.a3; hz2.dec_src_used_i = s.used; hz2.ex_valid_i = s.ev;
        hz2.ex_mem_read_i = s.mr; hz2.ex_reg_write_i = s.rw; hz2.ex_dest_addr_i = s.dest;
        hz2.ex_multi_cycle_i = s.mul; hz2.ex_branch_taken_i = s.br;
        hz3.dec_valid_i = s.dv; hz3.dec_src1_addr_i = s.a1; hz3.dec_src2_addr_i = s.a2;
        hz3.dec_src3_addr_i = s.a3; hz3.dec_src_used_i = s.used; hz3.ex_valid_i = s.ev;
        hz3.ex_mem_read_i = s.mr; hz3.ex_reg_write_i = s.rw; hz3.ex_dest_addr_i = s.dest;
        hz3.ex_multi_cycle_i = s.mul; hz3.ex_branch_taken_i = s.br;
        hz5.dec_valid_i = s.dv; hz5.dec_src1_addr_i = s.a1; hz5.dec_src2_addr_i = s.a2;
        hz5.dec_src3_addr_i = s.a3; hz5.dec_src_used_i = s.used; hz5.ex_valid_i = s.ev;
        hz5.ex_mem_read_i = s.mr; hz5.ex_reg_write_i = s.rw; hz5.ex_dest_addr_i = s.dest;
        hz5.ex_multi_cycle_i = s.mul; hz5.ex_branch_taken_i = s.br;
    endtask

    task automatic gather();
        a_h[0] = hz2.fd_hold_o; a_f[0] = hz2.fd_flush_o; a_dh[0] = hz2.de_hold_o;
        a_b[0] = hz2.de_bubble_o; a_cnt[0] = hz2.stall_cnt_o; a_m[0] = hz2.dbg_multi;
        a_h[1] = hz3.fd_hold_o; a_f[1] = hz3.fd_flush_o; a_dh[1] = hz3.de_hold_o;
        a_b[1] = hz3.de_bubble_o; a_cnt[1] = hz3.stall_cnt_o; a_m[1] = hz3.dbg_multi;
        a_h[2] = hz5.fd_hold_o; a_f[2] = hz5.fd_flush_o; a_dh[2] = hz5.de_hold_o;
        a_b[2] = hz5.de_bubble_o; a_cnt[2] = hz5.stall_cnt_o; a_m[2] = hz5.dbg_multi;
    endtask

    // Reference: occ counts how many cycles the current multi-cycle op has already spent
    // in execute (0 = none in progress). The op stalls for its first mc-1 cycles.
    function automatic void model_eval(input stim_t s, input int cur_occ, input int mc,
                                       output logic h, output logic f, output logic dh,
                                       output logic b, output int occ_n);
        logic [3:0] addr [3];
        logic       hit;
        addr[0] = s.a1; addr[1] = s.a2; addr[2] = s.a3;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) if (s.used[k] && addr[k] == s.dest) hit = 1'b1;
        h = 1'b0; f = 1'b0; dh = 1'b0; b = 1'b0; occ_n = cur_occ;
        if (s.ev && s.br) begin
            f = 1'b1; b = 1'b1; occ_n = 0;
        end else if (cur_occ > 0) begin
            if (cur_occ < mc - 1) begin h = 1'b1; dh = 1'b1; end
            occ_n = (cur_occ >= mc - 1) ? 0 : cur_occ + 1;
        end else if (s.ev && s.mul) begin
            h = 1'b1; dh = 1'b1; occ_n = 1;
        end else if (s.ev && s.mr && s.rw && s.dv && hit) begin
            h = 1'b1; b = 1'b1;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin occ[i] = 0; mcnt[i] = 0; end
    endtask

    task automatic step(input stim_t s, input bit do_check);
        logic eh, ef, edh, eb;
        int   on;
        @(posedge clk);
        #1;
        drive(s);
        @(negedge clk);
        gather();
        for (int i = 0; i < 3; i++) begin
            eh = 1'b0; ef = 1'b0; edh = 1'b0; eb = 1'b0; on = 0;
            if (rst_n) model_eval(s, occ[i], mc_tab[i], eh, ef, edh, eb, on);
            if (do_check) begin
                check("fd_hold",   i, 32'(a_h[i]),  32'(eh));
                check("fd_flush",  i, 32'(a_f[i]),  32'(ef));
                check("de_hold",   i, 32'(a_dh[i]), 32'(edh));
                check("de_bubble", i, 32'(a_b[i]),  32'(eb));
                check("stall_cnt", i, 32'(a_cnt[i]), 32'(mcnt[i]));
            end
            if (rst_n) begin
                occ[i] = on;
                if (eh && mcnt[i] < 65535) mcnt[i]++;
            end
        end
    endtask

    task automatic do_reset();
        drive(nop);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    stim_t lu, mul_s, s;
    logic  h2_tr [6], h3_tr [6], h5_tr [6], m3_tr [6];
    logic  exp_h2 [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic  exp_h3 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic  exp_h5 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic  exp_m3 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        nop   = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        lu    = mk(1, 4'd1, 4'd3, 4'd5, 3'b010, 1, 1, 1, 4'd3, 0, 0);
        mul_s = mk(1, 4'd1, 4'd2, 4'd4, 3'b001, 1, 0, 1, 4'd9, 1, 0);

        //                  dv a1 a2 a3 used    ev mr rw dest mul br      h  f  dh b
        vecs[0]  = '{mk(1, 1, 3, 5, 3'b010, 1, 1, 1, 3, 0, 0), 1, 0, 0, 1};
        vecs[1]  = '{mk(1, 3, 3, 3, 3'b000, 1, 1, 1, 3, 0, 0), 0, 0, 0, 0};
        vecs[2]  = '{mk(1, 1, 3, 5, 3'b010, 0, 1, 1, 3, 0, 0), 0, 0, 0, 0};
        vecs[3]  = '{mk(1, 7, 2, 5, 3'b001, 1, 1, 1, 7, 0, 0), 1, 0, 0, 1};
        vecs[4]  = '{mk(1, 1, 2, 15, 3'b100, 1, 1, 1, 15, 0, 0), 1, 0, 0, 1};
        vecs[5]  = '{mk(1, 1, 2, 6, 3'b011, 1, 1, 1, 6, 0, 0), 0, 0, 0, 0};
        vecs[6]  = '{mk(1, 1, 3, 5, 3'b010, 1, 1, 0, 3, 0, 0), 0, 0, 0, 0};
        vecs[7]  = '{mk(1, 1, 3, 5, 3'b010, 1, 0, 1, 3, 0, 0), 0, 0, 0, 0};
        vecs[8]  = '{mk(0, 1, 3, 5, 3'b010, 1, 1, 1, 3, 0, 0), 0, 0, 0, 0};
        vecs[9]  = '{mk(1, 1, 3, 5, 3'b010, 1, 1, 1, 3, 0, 1), 0, 1, 0, 1};
        vecs[10] = '{mk(1, 1, 3, 5, 3'b010, 0, 1, 1, 3, 0, 1), 0, 0, 0, 0};
        vecs[11] = '{mk(1, 1, 2, 4, 3'b001, 1, 0, 1, 9, 1, 0), 1, 0, 1, 0};
        vecs[12] = '{mk(1, 1, 3, 5, 3'b010, 1, 1, 1, 3, 1, 0), 1, 0, 1, 0};
        vecs[13] = '{mk(1, 1, 2, 4, 3'b001, 1, 0, 1, 9, 1, 1), 0, 1, 0, 1};

        drive(nop);
        rst_n = 1'b0;
        model_reset();
        #12;
        gather();
        for (int i = 0; i < 3; i++) begin
            check("reset_fd_hold", i, 32'(a_h[i]), 32'd0);
            check("reset_de_bubble", i, 32'(a_b[i]), 32'd0);
            check("reset_stall_cnt", i, 32'(a_cnt[i]), 32'd0);
            check("reset_state", i, 32'(a_m[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table, each entry started from IDLE and drained afterwards.
        for (int v = 0; v < 14; v++) begin
            step(vecs[v].in, 1'b1);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("vec%0d_fd_hold", v),   i, 32'(a_h[i]),  32'(vecs[v].h));
                check($sformatf("vec%0d_fd_flush", v),  i, 32'(a_f[i]),  32'(vecs[v].f));
                check($sformatf("vec%0d_de_hold", v),   i, 32'(a_dh[i]), 32'(vecs[v].dh));
                check($sformatf("vec%0d_de_bubble", v), i, 32'(a_b[i]),  32'(vecs[v].b));
            end
            repeat (5) step(nop, 1'b1);
        end

        // Load-use costs one stall cycle; the bubbled execute slot clears the hazard.
        do_reset();
        step(lu, 1'b1);
        check("lu_hold", 1, 32'(a_h[1]), 32'd1);
        s = lu; s.ev = 1'b0;
        step(s, 1'b1);
        check("lu_clear", 1, 32'(a_h[1]), 32'd0);
        step(nop, 1'b1);
        for (int i = 0; i < 3; i++) check("lu_stall_cnt", i, 32'(a_cnt[i]), 32'd1);

        // Multi-cycle op: stall traces for MULT_CYCLES 2, 3 and 5.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step((c == 0) ? mul_s : nop, 1'b1);
            h2_tr[c] = a_h[0]; h3_tr[c] = a_h[1]; h5_tr[c] = a_h[2]; m3_tr[c] = a_m[1];
        end
        for (int c = 0; c < 6; c++) begin
            check($sformatf("mul_trace%0d", c), 0, 32'(h2_tr[c]), 32'(exp_h2[c]));
            check($sformatf("mul_trace%0d", c), 1, 32'(h3_tr[c]), 32'(exp_h3[c]));
            check($sformatf("mul_trace%0d", c), 2, 32'(h5_tr[c]), 32'(exp_h5[c]));
            check($sformatf("mul_state%0d", c), 1, 32'(m3_tr[c]), 32'(exp_m3[c]));
        end
        check("mul_stall_cnt", 0, 32'(a_cnt[0]), 32'd1);
        check("mul_stall_cnt", 1, 32'(a_cnt[1]), 32'd2);
        check("mul_stall_cnt", 2, 32'(a_cnt[2]), 32'd4);

        // Branch outranks a simultaneous load-use match and does not count as a stall.
        do_reset();
        s = lu; s.br = 1'b1;
        step(s, 1'b1);
        check("br_flush", 1, 32'(a_f[1]), 32'd1);
        check("br_hold", 1, 32'(a_h[1]), 32'd0);
        step(nop, 1'b1);
        check("br_stall_cnt", 1, 32'(a_cnt[1]), 32'd0);

        // Reset asserted in the second stall cycle of a 5-cycle op.
        do_reset();
        step(mul_s, 1'b1);
        step(mul_s, 1'b1);
        check("rstmul_pre_hold", 2, 32'(a_h[2]), 32'd1);
        check("rstmul_pre_cnt", 2, 32'(a_cnt[2]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        gather();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check("rstmul_fd_hold", i, 32'(a_h[i]), 32'd0);
            check("rstmul_de_hold", i, 32'(a_dh[i]), 32'd0);
            check("rstmul_stall_cnt", i, 32'(a_cnt[i]), 32'd0);
            check("rstmul_state", i, 32'(a_m[i]), 32'd0);
        end
        step(lu, 1'b1);
        step(lu, 1'b1);
        drive(nop);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(nop, 1'b1);
            check("rstmul_after_hold", 2, 32'(a_h[2]), 32'd0);
        end

        // Randomised traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s.dv   = ($urandom_range(0, 9) < 8);
            s.a1   = 4'($urandom_range(0, 3));
            s.a2   = 4'($urandom_range(0, 3));
            s.a3   = 4'($urandom_range(0, 3));
            s.used = 3'($urandom_range(0, 7));
            s.ev   = ($urandom_range(0, 9) < 8);
            s.mr   = ($urandom_range(0, 1) == 1);
            s.rw   = ($urandom_range(0, 9) < 7);
            s.dest = 4'($urandom_range(0, 3));
            s.mul  = ($urandom_range(0, 19) < 3);
            s.br   = ($urandom_range(0, 9) == 0);
            step(s, 1'b1);
        end

        // Saturation of the stall counter under a permanent load-use.
        do_reset();
        for (int n = 0; n < 65540; n++) step(lu, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(lu, 1'b1);
            for (int i = 0; i < 3; i++) check("sat_stall_cnt", i, 32'(a_cnt[i]), 32'h0000FFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
